// File: rtl/fill_ar_mo.sv
// Fill-request issuer: pops miss entries from the AR FIFO, issues line-sized INCR AXI reads with
// rotating ARIDs, and logs {ARID, TID, line addr} into the RMiss FIFO for response matching.

`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 512
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef TID_WIDTH
`define TID_WIDTH 8
`endif
`ifndef AXI_ID
`define AXI_ID 2
`endif

module fill_ar_mo #(
  parameter int ADDR_WIDTH      = `AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH      = `AXI_DATA_WIDTH,
  parameter int ID_WIDTH        = `AXI_ID_WIDTH,
  parameter int TID_WIDTH       = `TID_WIDTH,
  parameter int ID_BASE         = `AXI_ID,
  parameter int NUM_IDS         = 4,
  parameter int LINE_BYTES      = 64,
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  output logic [ID_WIDTH-1:0]                    arid_o,
  output logic [ADDR_WIDTH-1:0]                  araddr_o,
  output logic [7:0]                             arlen_o,
  output logic [2:0]                             arsize_o,
  output logic [1:0]                             arburst_o,
  output logic                                   arvalid_o,
  input  logic                                   arready_i,
  input  logic                                   arfifo_aempty_i,
  output logic                                   arfifo_rden_o,
  input  logic [TID_WIDTH+ADDR_WIDTH-1:0]        arfifo_data_i,
  input  logic                                   rmfifo_afull_i,
  output logic                                   rmfifo_wren_o,
  output logic [ID_WIDTH+TID_WIDTH+ADDR_WIDTH-1:0] rmfifo_data_o,
  input  logic                                   rdone_i,
  output logic [CNT_WIDTH-1:0]                   outstanding_o,
  output logic                                   err_underflow_o
);

  localparam int BEAT_BYTES = DATA_WIDTH / 8;
  localparam int PTR_W      = (NUM_IDS > 1) ? $clog2(NUM_IDS) : 1;
  localparam logic [7:0] ARLEN  = 8'(LINE_BYTES / BEAT_BYTES - 1);
  localparam logic [2:0] ARSIZE = 3'($clog2(BEAT_BYTES));
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(LINE_BYTES - 1);

  logic                  valid_q, valid_d;
  logic [ID_WIDTH-1:0]   arid_q, arid_d;
  logic [TID_WIDTH-1:0]  tid_q, tid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [PTR_W-1:0]      idPtr_q, idPtr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic                  hs;
  logic                  load;
  logic [TID_WIDTH-1:0]  tidIn;
  logic [ADDR_WIDTH-1:0] addrIn;

  assign tidIn  = arfifo_data_i[TID_WIDTH+ADDR_WIDTH-1:ADDR_WIDTH];
  assign addrIn = arfifo_data_i[ADDR_WIDTH-1:0];

  // Credits are reserved at load against the registered count; rdone_i never bypasses into it.
  assign hs   = valid_q & arready_i;
  assign load = ~arfifo_aempty_i & ~rmfifo_afull_i &
                (cnt_q < CNT_WIDTH'(MAX_OUTSTANDING)) & (~valid_q | hs);

  // A load in the same cycle as a handshake must take the ARID after the one leaving now.
  always_comb begin
    idPtr_d = idPtr_q;
    if (hs) begin
      if (idPtr_q == PTR_W'(NUM_IDS - 1)) idPtr_d = '0;
      else                                idPtr_d = idPtr_q + PTR_W'(1);
    end
  end

  always_comb begin
    valid_d = valid_q;
    arid_d  = arid_q;
    tid_d   = tid_q;
    addr_d  = addr_q;
    if (load) begin
      valid_d = 1'b1;
      arid_d  = ID_WIDTH'(ID_BASE) + ID_WIDTH'(idPtr_d);
      tid_d   = tidIn;
      addr_d  = addrIn & ALIGN_MASK;
    end else if (hs) begin
      valid_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    unique case ({load, rdone_i})
      2'b10: cnt_d = cnt_q + CNT_WIDTH'(1);
      2'b01: begin
        if (cnt_q == '0) err_d = 1'b1;
        else             cnt_d = cnt_q - CNT_WIDTH'(1);
      end
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      arid_q  <= '0;
      tid_q   <= '0;
      addr_q  <= '0;
      idPtr_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      arid_q  <= arid_d;
      tid_q   <= tid_d;
      addr_q  <= addr_d;
      idPtr_q <= idPtr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign arid_o          = arid_q;
  assign araddr_o        = addr_q;
  assign arlen_o         = ARLEN;
  assign arsize_o        = ARSIZE;
  assign arburst_o       = 2'b01;
  assign arvalid_o       = valid_q;
  assign arfifo_rden_o   = load;
  assign rmfifo_wren_o   = hs;
  assign rmfifo_data_o   = {arid_q, tid_q, addr_q};
  assign outstanding_o   = cnt_q;
  assign err_underflow_o = err_q;

endmodule

// File: tb/tb_fill_ar_mo.sv
// Bench for fill_ar_mo: FWFT FIFO model feeding the DUT, scoreboard of expected ARs, and
// hand-timed sequences for backpressure, almost-full, credit limit, reset and underflow.

module tb_fill_ar_mo;

  localparam int AW      = 32;
  localparam int DW      = 512;
  localparam int IW      = 4;
  localparam int TW      = 8;
  localparam int ID_BASE = 2;
  localparam int NUM_IDS = 4;
  localparam int LINE    = 64;
  localparam int MAXO    = 3;
  localparam int CW      = $clog2(MAXO + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic [IW-1:0]     arid;
  logic [AW-1:0]     araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic              arfifoAempty;
  logic              arfifoRden;
  logic [TW+AW-1:0]  arfifoData;
  logic              rmfifoAfull;
  logic              rmfifoWren;
  logic [IW+TW+AW-1:0] rmfifoData;
  logic              rdone;
  logic [CW-1:0]     outstanding;
  logic              errUnderflow;

  always #5 clk = ~clk;

  fill_ar_mo #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .TID_WIDTH(TW), .ID_BASE(ID_BASE),
    .NUM_IDS(NUM_IDS), .LINE_BYTES(LINE), .MAX_OUTSTANDING(MAXO), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .arid_o(arid), .araddr_o(araddr), .arlen_o(arlen), .arsize_o(arsize),
    .arburst_o(arburst), .arvalid_o(arvalid), .arready_i(arready),
    .arfifo_aempty_i(arfifoAempty), .arfifo_rden_o(arfifoRden), .arfifo_data_i(arfifoData),
    .rmfifo_afull_i(rmfifoAfull), .rmfifo_wren_o(rmfifoWren), .rmfifo_data_o(rmfifoData),
    .rdone_i(rdone), .outstanding_o(outstanding), .err_underflow_o(errUnderflow)
  );

  typedef struct {
    logic [TW-1:0] tid;
    logic [AW-1:0] addr;
    logic [AW-1:0] expAddr;
  } vecT;

  typedef struct {
    logic [TW-1:0] tid;
    logic [AW-1:0] addr;
  } expT;

  logic [TW+AW-1:0] fifoQ[$];
  expT              expQ[$];
  vecT              table0[6];
  int total = 0;
  int bad = 0;
  int hsModel = 0;
  int hsCount = 0;
  int modelCnt = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, act, req);
    end
  endtask

  task automatic refreshFifo();
    arfifoAempty = (fifoQ.size() == 0);
    arfifoData   = (fifoQ.size() != 0) ? fifoQ[0] : '0;
  endtask

  // Push one miss into the FIFO model and the matching expected AR into the scoreboard.
  task automatic applyStimulus(input logic [TW-1:0] tid, input logic [AW-1:0] addr,
                               input logic [AW-1:0] expAddr);
    expT e;
    e.tid  = tid;
    e.addr = expAddr;
    fifoQ.push_back({tid, addr});
    expQ.push_back(e);
    refreshFifo();
  endtask

  task automatic clearModel();
    fifoQ.delete();
    expQ.delete();
    hsModel  = 0;
    modelCnt = 0;
    refreshFifo();
  endtask

  // Called at the falling edge: credit-count model plus scoreboard pop on every handshake.
  task automatic monitor();
    expT e;
    logic [IW-1:0] expId;
    if (!rst) begin
      checkOutput("outstanding_model", 64'(outstanding), 64'(modelCnt));
      if (arvalid && arready) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_ar: got handshake addr 0x%0h want none", araddr);
        end else begin
          e = expQ.pop_front();
          expId = IW'(ID_BASE + (hsModel % NUM_IDS));
          checkOutput("sb_araddr", 64'(araddr), 64'(e.addr));
          checkOutput("sb_arid", 64'(arid), 64'(expId));
          checkOutput("sb_wren", 64'(rmfifoWren), 64'(1));
          checkOutput("sb_rmdata", 64'(rmfifoData), 64'({expId, e.tid, e.addr}));
          hsModel++;
          hsCount++;
        end
      end else begin
        checkOutput("wren_idle", 64'(rmfifoWren), 64'(0));
      end
      if (arfifoRden && !rdone) modelCnt++;
      else if (!arfifoRden && rdone && modelCnt > 0) modelCnt--;
    end
  endtask

  // Advance one cycle: returns at posedge+2 with the FIFO model already popped if needed.
  task automatic step();
    logic popNow;
    @(negedge clk);
    monitor();
    popNow = arfifoRden && !rst;
    @(posedge clk);
    #1;
    if (popNow && fifoQ.size() > 0) void'(fifoQ.pop_front());
    refreshFifo();
    #1;
  endtask

  initial begin
    arready = 1'b0;
    rmfifoAfull = 1'b0;
    rdone = 1'b0;
    refreshFifo();
    rst = 1'b1;
    #1;
    checkOutput("rst_arvalid", 64'(arvalid), 64'(0));
    checkOutput("rst_rden", 64'(arfifoRden), 64'(0));
    checkOutput("rst_outstanding", 64'(outstanding), 64'(0));
    checkOutput("rst_err", 64'(errUnderflow), 64'(0));
    checkOutput("rst_rmdata", 64'(rmfifoData), 64'(0));
    checkOutput("arlen", 64'(arlen), 64'(0));
    checkOutput("arsize", 64'(arsize), 64'(6));
    checkOutput("arburst", 64'(arburst), 64'(1));
    step();
    step();
    rst = 1'b0;
    step();

    // Single miss followed by a back-to-back stream with rotating ARIDs.
    table0[0] = '{tid: 8'h03, addr: 32'h1234_567F, expAddr: 32'h1234_5640};
    table0[1] = '{tid: 8'h10, addr: 32'h0000_0040, expAddr: 32'h0000_0040};
    table0[2] = '{tid: 8'h21, addr: 32'hFFFF_FFFF, expAddr: 32'hFFFF_FFC0};
    table0[3] = '{tid: 8'h32, addr: 32'h0000_003F, expAddr: 32'h0000_0000};
    table0[4] = '{tid: 8'hA4, addr: 32'hDEAD_BEEF, expAddr: 32'hDEAD_BEC0};
    table0[5] = '{tid: 8'hFF, addr: 32'h0BAD_F00D, expAddr: 32'h0BAD_F000};
    for (int i = 0; i < 6; i++) applyStimulus(table0[i].tid, table0[i].addr, table0[i].expAddr);
    arready = 1'b1;
    #1;
    checkOutput("single_rden_c0", 64'(arfifoRden), 64'(1));
    checkOutput("single_arvalid_c0", 64'(arvalid), 64'(0));
    step();
    checkOutput("single_arvalid_c1", 64'(arvalid), 64'(1));
    checkOutput("single_araddr", 64'(araddr), 64'(32'h1234_5640));
    checkOutput("single_arid", 64'(arid), 64'(ID_BASE));
    checkOutput("single_wren", 64'(rmfifoWren), 64'(1));
    checkOutput("single_outstanding", 64'(outstanding), 64'(1));
    for (int i = 1; i <= 6; i++) begin
      rdone = 1'b1;
      step();
    end
    rdone = 1'b0;
    checkOutput("b2b_hs_count", 64'(hsCount), 64'(6));
    checkOutput("b2b_sb_empty", 64'(expQ.size()), 64'(0));
    checkOutput("b2b_outstanding", 64'(outstanding), 64'(0));

    // Backpressure with afull rising mid-stall, then almost-full gating a fresh load.
    arready = 1'b0;
    applyStimulus(8'h11, 32'h0000_1000, 32'h0000_1000);
    applyStimulus(8'h22, 32'h0000_20C5, 32'h0000_20C0);
    #1;
    checkOutput("bp_rden_c0", 64'(arfifoRden), 64'(1));
    step();
    for (int c = 1; c <= 5; c++) begin
      if (c == 3) rmfifoAfull = 1'b1;
      #1;
      checkOutput("bp_arvalid", 64'(arvalid), 64'(1));
      checkOutput("bp_araddr", 64'(araddr), 64'(32'h0000_1000));
      checkOutput("bp_arid", 64'(arid), 64'(ID_BASE + 2));
      checkOutput("bp_rden", 64'(arfifoRden), 64'(0));
      checkOutput("bp_wren", 64'(rmfifoWren), 64'(0));
      step();
    end
    arready = 1'b1;
    #1;
    checkOutput("bp_push_at_hs", 64'(rmfifoWren), 64'(1));
    checkOutput("bp_rden_afull", 64'(arfifoRden), 64'(0));
    step();
    #1;
    checkOutput("afull_arvalid", 64'(arvalid), 64'(0));
    checkOutput("afull_rden", 64'(arfifoRden), 64'(0));
    checkOutput("afull_outstanding", 64'(outstanding), 64'(1));
    step();
    rmfifoAfull = 1'b0;
    #1;
    checkOutput("afull_release_rden", 64'(arfifoRden), 64'(1));
    step();
    checkOutput("bp2_arvalid", 64'(arvalid), 64'(1));
    checkOutput("bp2_araddr", 64'(araddr), 64'(32'h0000_20C0));
    checkOutput("bp2_arid", 64'(arid), 64'(ID_BASE + 3));
    checkOutput("bp2_outstanding", 64'(outstanding), 64'(2));
    rdone = 1'b1;
    step();
    step();
    rdone = 1'b0;
    checkOutput("bp_drained", 64'(outstanding), 64'(0));

    // Credit limit: three fills reserve every credit; rdone releases them one at a time.
    for (int i = 0; i < 6; i++)
      applyStimulus(8'(8'h40 + i), 32'h8000_0000 + 32'(i * 'h41), 32'h8000_0000 + 32'(i * 'h40));
    #1;
    checkOutput("cr_rden_c0", 64'(arfifoRden), 64'(1));
    step();
    step();
    step();
    #1;
    checkOutput("cr_full_rden", 64'(arfifoRden), 64'(0));
    checkOutput("cr_full_cnt", 64'(outstanding), 64'(3));
    checkOutput("cr_full_arvalid", 64'(arvalid), 64'(1));
    step();
    #1;
    checkOutput("cr_idle_arvalid", 64'(arvalid), 64'(0));
    checkOutput("cr_idle_rden", 64'(arfifoRden), 64'(0));
    step();
    rdone = 1'b1;
    #1;
    checkOutput("cr_no_bypass", 64'(arfifoRden), 64'(0));
    step();
    rdone = 1'b0;
    #1;
    checkOutput("cr_released_cnt", 64'(outstanding), 64'(2));
    checkOutput("cr_released_rden", 64'(arfifoRden), 64'(1));
    step();
    checkOutput("cr_refill_cnt", 64'(outstanding), 64'(3));
    checkOutput("cr_refill_rden", 64'(arfifoRden), 64'(0));
    rdone = 1'b1;
    step();
    #1;
    checkOutput("cr_sim_rden", 64'(arfifoRden), 64'(1));
    step();
    rdone = 1'b0;
    checkOutput("cr_sim_cnt", 64'(outstanding), 64'(2));
    checkOutput("cr_sim_arvalid", 64'(arvalid), 64'(1));
    step();
    checkOutput("cr_pre_rst_cnt", 64'(outstanding), 64'(3));
    checkOutput("cr_pre_rst_arvalid", 64'(arvalid), 64'(1));

    // Reset mid-burst with a held entry and every credit in use.
    arready = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("mrst_arvalid", 64'(arvalid), 64'(0));
    checkOutput("mrst_rden", 64'(arfifoRden), 64'(0));
    checkOutput("mrst_wren", 64'(rmfifoWren), 64'(0));
    checkOutput("mrst_araddr", 64'(araddr), 64'(0));
    checkOutput("mrst_arid", 64'(arid), 64'(0));
    checkOutput("mrst_rmdata", 64'(rmfifoData), 64'(0));
    checkOutput("mrst_outstanding", 64'(outstanding), 64'(0));
    clearModel();
    step();
    rst = 1'b0;
    step();
    checkOutput("post_rst_cnt", 64'(outstanding), 64'(0));

    // Underflow: rdone with nothing outstanding sets a sticky error.
    rdone = 1'b1;
    #1;
    checkOutput("uf_err_before", 64'(errUnderflow), 64'(0));
    step();
    rdone = 1'b0;
    checkOutput("uf_err_set", 64'(errUnderflow), 64'(1));
    checkOutput("uf_cnt_zero", 64'(outstanding), 64'(0));
    step();
    step();
    checkOutput("uf_err_sticky", 64'(errUnderflow), 64'(1));
    rst = 1'b1;
    #1;
    checkOutput("uf_err_cleared", 64'(errUnderflow), 64'(0));
    step();
    rst = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
